// File: rtl/serial_addsub.sv
// serial_addsub: multi-cycle WIDTH-bit adder/subtractor, DIGIT bits per clock LSB-first
// with a registered carry/borrow between digits and a start/busy/done handshake.
module serial_addsub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    if (WIDTH < 2 || WIDTH % DIGIT != 0) begin : g_bad_params
        $error("serial_addsub: WIDTH must be >= 2 and a multiple of DIGIT");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nx;

    logic [WIDTH-1:0] a_sh, b_sh, acc, acc_nx;
    logic [CW-1:0]    cnt;
    logic             mode_q, a_msb, b_msb, carry;
    logic [DIGIT-1:0] a_k, b_k, dig;
    logic [DIGIT:0]   sum, dif;
    logic             c_nx, last, take, r_msb, ovf_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // IDLE and DONE behave alike: start launches a new operation without a bubble
    always_comb begin
        state_nx = (state == RUN) ? (last ? DONE : RUN) : (start ? RUN : IDLE);
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    // one digit slice: operands are shifted right so the live digit is always at bit 0
    always_comb begin
        a_k    = a_sh[DIGIT-1:0];
        b_k    = b_sh[DIGIT-1:0];
        sum    = {1'b0, a_k} + {1'b0, b_k} + {{DIGIT{1'b0}}, carry};
        dif    = {1'b0, a_k} - {1'b0, b_k} - {{DIGIT{1'b0}}, carry};
        dig    = mode_q ? dif[DIGIT-1:0] : sum[DIGIT-1:0];
        c_nx   = mode_q ? dif[DIGIT] : sum[DIGIT];
        acc_nx = WIDTH'({dig, acc} >> DIGIT);
        r_msb  = acc_nx[WIDTH-1];
        ovf_nx = mode_q ? (a_msb != b_msb) & (r_msb != a_msb)
                        : (a_msb == b_msb) & (r_msb != a_msb);
        last   = (cnt == CW'(N - 1));
        take   = start & (state != RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh     <= '0;
            b_sh     <= '0;
            acc      <= '0;
            cnt      <= '0;
            mode_q   <= 1'b0;
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            carry    <= 1'b0;
            result   <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else if (take) begin
            a_sh   <= a;
            b_sh   <= b;
            mode_q <= mode;
            a_msb  <= a[WIDTH-1];
            b_msb  <= b[WIDTH-1];
            carry  <= 1'b0;
            cnt    <= '0;
        end else if (busy) begin
            a_sh  <= a_sh >> DIGIT;
            b_sh  <= b_sh >> DIGIT;
            carry <= c_nx;
            acc   <= acc_nx;
            cnt   <= cnt + 1'b1;
            if (last) begin
                result   <= acc_nx;
                cout     <= c_nx;
                overflow <= ovf_nx;
            end
        end
    end
endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub: directed vectors, handshake corner cases and exhaustive
// 4-bit checks (DIGIT=1,2,4) for serial_addsub.
module tb_serial_addsub;
    typedef struct {
        logic       m;
        logic [7:0] a, b, r;
        logic       c, v;
    } vec_t;

    logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, mode = 1'b0;
    logic [7:0] a = '0, b = '0, result;
    logic       busy, done, cout, overflow;
    int         cmp = 0, bad = 0;

    logic       xs[3], xm[3], xbsy[3], xdn[3], xco[3], xov[3];
    logic [3:0] xa[3], xb[3], xr[3];

    always #5 clk = ~clk;

    serial_addsub #(.WIDTH(8), .DIGIT(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .cout(cout), .overflow(overflow)
    );

    for (genvar j = 0; j < 3; j++) begin : g_w4
        serial_addsub #(.WIDTH(4), .DIGIT(1 << j)) u (
            .clk(clk), .rst_n(rst_n), .start(xs[j]), .mode(xm[j]), .a(xa[j]), .b(xb[j]),
            .busy(xbsy[j]), .done(xdn[j]), .result(xr[j]), .cout(xco[j]), .overflow(xov[j])
        );
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        cmp++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // called half a cycle after the start edge; counts clocks until done
    task automatic wait_done(output int lat, output int bc);
        lat = 0;
        bc  = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy) bc++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run8(input vec_t v, input string nm);
        int lat, bc;
        start = 1'b1; mode = v.m; a = v.a; b = v.b;
        @(negedge clk);
        start = 1'b0; mode = ~v.m; a = ~v.a; b = ~v.b;
        wait_done(lat, bc);
        chk({nm, "_lat"}, lat, 8);
        chk({nm, "_busy"}, bc, 8);
        chk({nm, "_res"}, result, v.r);
        chk({nm, "_cout"}, cout, v.c);
        chk({nm, "_ovf"}, overflow, v.v);
        @(negedge clk);
        chk({nm, "_pulse"}, {busy, done}, 2'b00);
    endtask

    initial begin
        vec_t vt[10];
        int   lat, bc, seen;
        vt[0] = '{1'b1, 8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
        vt[1] = '{1'b1, 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
        vt[2] = '{1'b1, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
        vt[3] = '{1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
        vt[4] = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
        vt[5] = '{1'b0, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0};
        vt[6] = '{1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
        vt[7] = '{1'b1, 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
        vt[8] = '{1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
        vt[9] = '{1'b0, 8'hA5, 8'h5A, 8'hFF, 1'b0, 1'b0};
        for (int j = 0; j < 3; j++) begin
            xs[j] = 1'b0; xm[j] = 1'b0; xa[j] = '0; xb[j] = '0;
        end

        #2;
        chk("rst_state", {busy, done, result, cout, overflow}, '0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_after_rst", {busy, done}, 2'b00);

        for (int i = 0; i < 10; i++) run8(vt[i], $sformatf("vec%0d", i));

        // start pulsed mid-run with different operands must be ignored
        start = 1'b1; mode = 1'b0; a = 8'h10; b = 8'h20;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1; mode = 1'b1; a = 8'hFF; b = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, bc);
        chk("ign_lat", lat, 4);
        chk("ign_res", {result, cout, overflow}, {8'h30, 2'b00});
        @(negedge clk);
        chk("ign_idle", {busy, done}, 2'b00);

        // start held through the run and the done cycle: back-to-back ops
        start = 1'b1; mode = 1'b0; a = 8'h01; b = 8'h02;
        @(negedge clk);
        mode = 1'b1; a = 8'h04; b = 8'h09;
        wait_done(lat, bc);
        chk("b2b_lat1", lat, 8);
        chk("b2b_res1", {result, cout, overflow}, {8'h03, 2'b00});
        @(negedge clk);
        start = 1'b0;
        chk("b2b_nobubble", {busy, done}, 2'b10);
        wait_done(lat, bc);
        chk("b2b_lat2", lat, 8);
        chk("b2b_res2", {result, cout, overflow}, {8'hFB, 2'b10});

        // async reset in the middle of a run
        @(negedge clk);
        start = 1'b1; mode = 1'b0; a = 8'h7F; b = 8'h01;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_clear", {busy, done, result, cout, overflow}, '0);
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) seen++;
        end
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk("abort_nodone", seen, 0);
        run8(vt[0], "post_rst");

        // exhaustive 4-bit: latency must be 4/DIGIT clocks
        for (int j = 0; j < 3; j++)
            for (int m = 0; m < 2; m++)
                for (int x = 0; x < 16; x++)
                    for (int y = 0; y < 16; y++) begin
                        int xl, sa, sb, s;
                        xs[j] = 1'b1; xm[j] = m[0]; xa[j] = x[3:0]; xb[j] = y[3:0];
                        @(negedge clk);
                        xs[j] = 1'b0;
                        xl = 0;
                        while (xdn[j] !== 1'b1 && xl < 40) begin
                            @(negedge clk);
                            xl++;
                        end
                        sa = (x > 7) ? x - 16 : x;
                        sb = (y > 7) ? y - 16 : y;
                        s  = (m == 1) ? sa - sb : sa + sb;
                        chk($sformatf("w4_d%0d_lat", 1 << j), xl, 4 >> j);
                        chk($sformatf("w4_d%0d_res m%0d %0d,%0d", 1 << j, m, x, y), xr[j],
                            ((m == 1) ? x - y : x + y) & 15);
                        chk($sformatf("w4_d%0d_cout m%0d %0d,%0d", 1 << j, m, x, y), xco[j],
                            (m == 1) ? (x < y) : (x + y > 15));
                        chk($sformatf("w4_d%0d_ovf m%0d %0d,%0d", 1 << j, m, x, y), xov[j],
                            (s < -8 || s > 7));
                        @(negedge clk);
                    end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end
endmodule
